moore_seq_detector: RTL and testbench
=====================================

// Module: moore_seq_detector
// PURPOSE
//  Moore-type serial pattern detector. Samples one bit per clock on seq and raises flag
//  for one cycle after the last bit of PATTERN is received. Leaf block on a serial bit
//  stream that feeds event/statistics logic. flag is a pure function of state, never of seq.
// PARAMETERS
//  PATTERN_W  4        pattern length in bits, legal 1..16 (elaboration error otherwise)
//  PATTERN    4'b1011  pattern to detect; MSB is the first bit received
//  OVERLAP    1        1 = overlapping matches allowed; 0 = restart from empty after a match
// PORTS
//  clk   in   1  clock; all state changes occur on the rising edge
//  rst   in   1  synchronous, active-high reset
//  seq   in   1  serial data bit, sampled on each rising clk edge
//  flag  out  1  match indicator, registered Moore output
// BEHAVIOUR
//  - One clock. Reset is synchronous and active-high. With rst=1 at an edge: state<=S0, flag<=0.
//    rst has priority over seq.
//  - States S0..SN, N=PATTERN_W. Sk = the first k pattern bits (MSB first) are matched.
//    SN is the match state.
//  - State register width: clog2(N+1). Encodings above N are unreachable.
//    If such an encoding is ever loaded, the next state is S0.
//  - Transition from Sk (k<N) on bit b:
//    - If b equals pattern bit k (counted from the MSB), go to S(k+1).
//    - Otherwise go to Sj, where j = length of the longest pattern prefix that is a suffix of
//      (matched k bits, then b). This is the KMP fallback, computed at elaboration.
//  - Transition from SN:
//    - OVERLAP=1: treat SN as Sf, f = longest proper border of PATTERN, then apply the rule above.
//    - OVERLAP=0: treat SN as S0, then apply the rule above.
//  - flag = (state==SN). It is registered with the state: high for the one cycle after the
//    edge that samples the final pattern bit.
//    - Latency: final bit sampled at edge t -> flag=1 during (t, t+1].
//  - Back-to-back matches (e.g. pattern 1111 with OVERLAP=1) keep flag high across
//    consecutive cycles.
//  - Reset mid-pattern discards partial progress. A match after reset needs the full pattern.
//  - seq must be stable around the rising edge. No enable and no handshake: every edge
//    consumes one bit.
// TESTING
//  Defaults. Stream 0101_1011_0110_1011_0100, one bit per clock, MSB first:
//   1. rst=1 for 2 edges, seq toggling -> flag=0 throughout; after release, state is S0.
//   2. Full stream -> flag pulses once after bits 4, 7, 10 and 15 (0-based). Each pulse is
//      one cycle wide. flag=0 elsewhere.
//   3. Same stream with OVERLAP=0 -> pulses only after bits 4, 10 and 15.
//   4. Input 1,0,1, then rst=1 for one edge, then 1 -> no pulse. Then 0,1,1 -> pulse after
//      the last 1.
//   5. PATTERN_W=4, PATTERN=4'b1111, OVERLAP=1, seq=1 for 6 clocks -> flag high for
//      3 consecutive cycles, starting after the 4th bit.
//   6. All-zero input for 50 cycles -> flag=0. Check that flag never depends on seq
//      combinationally: toggle seq between edges and flag holds.

Source files
------------

// File: rtl/moore_seq_detector_if.sv
// moore_seq_detector_if: serial bit in, match flag out
interface moore_seq_detector_if;
  logic seq;
  logic flag;
  modport master (output seq, input flag);
  modport slave (input seq, output flag);
endinterface

// File: rtl/moore_seq_detector.sv
// moore_seq_detector: Moore serial pattern detector with an elaboration-time KMP transition table
module moore_seq_detector #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
  parameter bit                   OVERLAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  moore_seq_detector_if.slave   bus
);
  localparam int SW = $clog2(PATTERN_W + 1);
  localparam int NS = 1 << SW;
  typedef enum logic [SW-1:0] {S0 = SW'(0), SN = SW'(PATTERN_W)} state_t;
  if (PATTERN_W < 1 || PATTERN_W > 16) begin : g_bad_width
    $error("moore_seq_detector: PATTERN_W must be 1..16");
  end
  function automatic logic pat(input int i);
    return PATTERN[PATTERN_W-1-i];
  endfunction
  function automatic int border();
    logic ok;
    for (int j = PATTERN_W - 1; j > 0; j--) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++) ok &= (pat(i) == pat(PATTERN_W - j + i));
      if (ok) return j;
    end
    return 0;
  endfunction
  // Longest pattern prefix that is a suffix of (matched prefix, b); encodings above N fall to S0
  function automatic int trans(input int k, input logic b);
    int m;
    int p;
    logic ok;
    if (k > PATTERN_W) return 0;
    m = (k == PATTERN_W) ? (OVERLAP ? border() : 0) : k;
    for (int j = m + 1; j > 0; j--) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++) begin
        p = m + 1 - j + i;
        ok &= (pat(i) == ((p == m) ? b : pat(p)));
      end
      if (ok) return j;
    end
    return 0;
  endfunction
  logic [SW-1:0] w_nxt0 [NS];
  logic [SW-1:0] w_nxt1 [NS];
  for (genvar k = 0; k < NS; k++) begin : g_tbl
    assign w_nxt0[k] = SW'(trans(k, 1'b0));
    assign w_nxt1[k] = SW'(trans(k, 1'b1));
  end
  state_t r_state;
  logic   r_flag;
  state_t w_next;
  assign w_next = state_t'(bus.seq ? w_nxt1[r_state] : w_nxt0[r_state]);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S0;
      r_flag  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_flag  <= (w_next == SN);
    end
  end
  assign bus.flag = r_flag;
endmodule

// File: tb/tb_moore_seq_detector.sv
// tb_moore_seq_detector: directed checks of overlap, non-overlap and all-ones pattern instances
module tb_moore_seq_detector;
  logic clk = 1'b0;
  logic rst;
  int ncmp = 0;
  int nfail = 0;
  moore_seq_detector_if if_a ();
  moore_seq_detector_if if_b ();
  moore_seq_detector_if if_c ();
  moore_seq_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  moore_seq_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  moore_seq_detector #(.PATTERN_W(4), .PATTERN(4'b1111), .OVERLAP(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(if_c));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic step(input logic a, input logic b, input logic c);
    if_a.seq = a;
    if_b.seq = b;
    if_c.seq = c;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [19:0] stream;
    logic [19:0] exp_a;
    logic [19:0] exp_b;
    logic [5:0] exp_c;
    logic s;
    stream = 20'b0101_1011_0110_1011_0100;
    exp_a = 20'h0;
    exp_a[4] = 1'b1;
    exp_a[7] = 1'b1;
    exp_a[10] = 1'b1;
    exp_a[15] = 1'b1;
    exp_b = 20'h0;
    exp_b[4] = 1'b1;
    exp_b[10] = 1'b1;
    exp_b[15] = 1'b1;
    exp_c = 6'b111000;
    rst = 1'b1;
    // reset held two edges with seq toggling
    step(1'b1, 1'b1, 1'b1);
    chk("rst0_a", if_a.flag, 1'b0);
    chk("rst0_c", if_c.flag, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("rst1_a", if_a.flag, 1'b0);
    chk("rst1_b", if_b.flag, 1'b0);
    chk("rst_state_a", dut_a.r_state == 3'd0, 1'b1);
    rst = 1'b0;
    // full stream, MSB first
    for (int i = 0; i < 20; i++) begin
      s = stream[19-i];
      step(s, s, 1'b0);
      chk($sformatf("ovl_bit%0d", i), if_a.flag, exp_a[i]);
      chk($sformatf("novl_bit%0d", i), if_b.flag, exp_b[i]);
    end
    // reset mid-pattern discards progress
    step(1'b1, 1'b1, 1'b0);
    chk("mid_1_a", if_a.flag, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("mid_0_a", if_a.flag, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("mid_1b_a", if_a.flag, 1'b0);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    chk("mid_rst_a", if_a.flag, 1'b0);
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    chk("post_rst_a", if_a.flag, 1'b0);
    chk("post_rst_b", if_b.flag, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("post_0_a", if_a.flag, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("post_1_a", if_a.flag, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("post_match_a", if_a.flag, 1'b1);
    chk("post_match_b", if_b.flag, 1'b1);
    // all-ones pattern, back-to-back matches; flag must ignore seq between edges
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b1);
      chk($sformatf("ones_bit%0d", i), if_c.flag, exp_c[i]);
      #3 if_c.seq = 1'b0;
      #1 chk($sformatf("ones_hold%0d", i), if_c.flag, exp_c[i]);
      if_c.seq = 1'b1;
    end
    // all-zero input, with seq pulsed high between edges
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk($sformatf("zero_a%0d", i), if_a.flag, 1'b0);
      chk($sformatf("zero_c%0d", i), if_c.flag, 1'b0);
      #3 begin
        if_a.seq = 1'b1;
        if_c.seq = 1'b1;
      end
      #1 chk($sformatf("zero_hold_a%0d", i), if_a.flag, 1'b0);
      chk($sformatf("zero_hold_c%0d", i), if_c.flag, 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
